// File: rtl/vga_timing_rx.sv
// Video timing receiver: locks onto incoming HS/VS timing, measures line and
// frame length, and emits active pixels with coordinates once timing is stable.
module vga_timing_rx #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int H_START  = 260,
   parameter int V_START  = 25,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hs,
   input  logic        vs,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        pix_valid,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic        sof,
   output logic        locked,
   output logic [11:0] h_total,
   output logic [11:0] v_total,
   output logic        err
);

   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;
   localparam logic [1:0] S_LOCKED  = 2'd3;

   localparam logic [11:0] CMAX = 12'hFFF;
   localparam logic [11:0] HB   = 12'(H_START);
   localparam logic [11:0] HE   = 12'(H_START + H_ACTIVE);
   localparam logic [11:0] VB   = 12'(V_START);
   localparam logic [11:0] VE   = 12'(V_START + V_ACTIVE);

   logic        hs1_q, hs2_q, vs1_q, vs2_q;
   logic [23:0] rgb1_q, rgb2_q, rgb3_q;
   logic        hs_lead, vs_lead;
   logic        line_start, frame_start;
   logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [11:0] h_len, v_len;
   logic        vs_pend_q, vs_pend_d;
   logic [11:0] h_total_q, h_total_d, v_total_q, v_total_d;
   logic [1:0]  state_q, state_d;
   logic [11:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
   logic        bad_q, bad_d;
   logic        err_q, err_d;
   logic        h_bad, v_bad, tmo;
   logic        act2, act3_q;
   logic [11:0] x3_q, y3_q;
   logic        valid_d, sof_d;
   logic        valid_q, sof_q;
   logic [11:0] px_q, py_q;
   logic [23:0] prgb_q;

   assign hs_lead = (hs1_q == SYNC_POL) && (hs2_q != SYNC_POL);
   assign vs_lead = (vs1_q == SYNC_POL) && (vs2_q != SYNC_POL);

   assign line_start  = hs_lead;
   assign frame_start = line_start && (vs_pend_q || vs_lead);

   assign h_len = h_cnt_q + 12'd1;
   assign v_len = v_cnt_q + 12'd1;

   always_comb begin
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      vs_pend_d = vs_pend_q;
      h_total_d = h_total_q;
      v_total_d = v_total_q;
      if (line_start) begin
         h_cnt_d   = 12'd0;
         h_total_d = h_len;
      end else if (h_cnt_q != CMAX) begin
         h_cnt_d = h_len;
      end
      if (frame_start) begin
         v_cnt_d   = 12'd0;
         v_total_d = v_len;
         vs_pend_d = 1'b0;
      end else begin
         if (line_start && v_cnt_q != CMAX)
            v_cnt_d = v_len;
         if (vs_lead)
            vs_pend_d = 1'b1;
      end
   end

   assign h_bad = line_start && (h_len != ref_h_q);
   assign v_bad = frame_start && (v_len != ref_v_q);
   // A fresh HS on the saturated cycle is a line start, not a timeout
   assign tmo   = (h_cnt_q == CMAX) && !line_start;

   always_comb begin
      state_d = state_q;
      ref_h_d = ref_h_q;
      ref_v_d = ref_v_q;
      bad_d   = bad_q;
      err_d   = 1'b0;
      if (tmo) begin
         state_d = S_SEARCH;
         err_d   = (state_q != S_SEARCH);
      end else begin
         case (state_q)
            S_SEARCH: begin
               if (frame_start)
                  state_d = S_MEASURE;
            end
            S_MEASURE: begin
               if (frame_start) begin
                  state_d = S_CHECK;
                  ref_h_d = h_len;
                  ref_v_d = v_len;
                  bad_d   = 1'b0;
               end
            end
            S_CHECK: begin
               if (frame_start) begin
                  if (bad_q || h_bad || v_bad) begin
                     ref_h_d = h_len;
                     ref_v_d = v_len;
                     bad_d   = 1'b0;
                  end else begin
                     state_d = S_LOCKED;
                  end
               end else if (h_bad) begin
                  bad_d = 1'b1;
               end
            end
            S_LOCKED: begin
               if (h_bad || v_bad) begin
                  state_d = S_MEASURE;
                  err_d   = 1'b1;
               end
            end
            default: state_d = S_SEARCH;
         endcase
      end
   end

   assign act2 = (state_q == S_LOCKED)
              && (h_cnt_q >= HB) && (h_cnt_q < HE)
              && (v_cnt_q >= VB) && (v_cnt_q < VE);

   // Gate on next state so pixels stop on the same cycle lock drops
   assign valid_d = act3_q && (state_d == S_LOCKED);
   assign sof_d   = valid_d && (x3_q == 12'd0) && (y3_q == 12'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs1_q     <= ~SYNC_POL;
         hs2_q     <= ~SYNC_POL;
         vs1_q     <= ~SYNC_POL;
         vs2_q     <= ~SYNC_POL;
         rgb1_q    <= '0;
         rgb2_q    <= '0;
         rgb3_q    <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         vs_pend_q <= 1'b0;
         h_total_q <= '0;
         v_total_q <= '0;
         state_q   <= S_SEARCH;
         ref_h_q   <= '0;
         ref_v_q   <= '0;
         bad_q     <= 1'b0;
         err_q     <= 1'b0;
         act3_q    <= 1'b0;
         x3_q      <= '0;
         y3_q      <= '0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         prgb_q    <= '0;
      end else begin
         hs1_q     <= hs;
         hs2_q     <= hs1_q;
         vs1_q     <= vs;
         vs2_q     <= vs1_q;
         rgb1_q    <= {r, g, b};
         rgb2_q    <= rgb1_q;
         rgb3_q    <= rgb2_q;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         vs_pend_q <= vs_pend_d;
         h_total_q <= h_total_d;
         v_total_q <= v_total_d;
         state_q   <= state_d;
         ref_h_q   <= ref_h_d;
         ref_v_q   <= ref_v_d;
         bad_q     <= bad_d;
         err_q     <= err_d;
         act3_q    <= act2;
         x3_q      <= h_cnt_q - HB;
         y3_q      <= v_cnt_q - VB;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         if (valid_d) begin
            px_q   <= x3_q;
            py_q   <= y3_q;
            prgb_q <= rgb3_q;
         end
      end
   end

   assign pix_valid = valid_q;
   assign pix_x     = px_q;
   assign pix_y     = py_q;
   assign pix_r     = prgb_q[23:16];
   assign pix_g     = prgb_q[15:8];
   assign pix_b     = prgb_q[7:0];
   assign sof       = sof_q;
   assign locked    = (state_q == S_LOCKED);
   assign h_total   = h_total_q;
   assign v_total   = v_total_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down raster (30x12 clocks,
// 16x6 active) with a per-frame expectation table and a pixel scoreboard.
module tb_vga_timing_rx;

   localparam int HA  = 16;
   localparam int VA  = 6;
   localparam int HST = 8;
   localparam int VST = 3;
   localparam int HT  = 30;
   localparam int VT  = 12;
   localparam int HSW = 4;
   localparam int VSW = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hs = 1'b0;
   logic        vs = 1'b0;
   logic [7:0]  r = '0;
   logic [7:0]  g = '0;
   logic [7:0]  b = '0;
   logic        pix_valid;
   logic [11:0] pix_x, pix_y;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        sof, locked, err;
   logic [11:0] h_total, v_total;

   vga_timing_rx #(
      .H_ACTIVE(HA), .V_ACTIVE(VA),
      .H_START(HST), .V_START(VST),
      .SYNC_POL(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .hs(hs), .vs(vs),
      .r(r), .g(g), .b(b),
      .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y),
      .pix_r(pix_r), .pix_g(pix_g),
      .pix_b(pix_b),
      .sof(sof), .locked(locked),
      .h_total(h_total), .v_total(v_total),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int act;
      int sl;
      bit vse;
      int rl;
      int e_lock;
      int e_pix;
      int e_sof;
      int e_err;
      bit ctot;
   } vec_t;

   vec_t tbl[16];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int a_cyc = 0;
   int frame_id = 0;
   int seen_id = 0;
   int exp_x = 0;
   int exp_y = 0;
   int pix_tot = 0;
   int sof_tot = 0;
   int err_tot = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [23:0] col(input int px, input int ln);
      logic [7:0] cr, cg, cb;
      cr = 8'(px * 7 + ln * 13);
      if (px == HST && ln == VST)
         cr = 8'hA5;
      cg = 8'(ln * 3 + 1);
      cb = 8'(px);
      return {cr, cg, cb};
   endfunction

   task automatic drive_frame(input int sl, input bit vse, input int rl);
      int len;
      frame_id++;
      for (int ln = 0; ln < VT; ln++) begin
         len = (ln == sl) ? HT - 1 : HT;
         for (int px = 0; px < len; px++) begin
            @(negedge clk);
            hs = (px < HSW);
            vs = (ln < VSW) || (vse && ln == VT - 1 && px == len - 1);
            {r, g, b} = col(px, ln);
            if (px == HST && ln == VST)
               a_cyc = cyc;
            if (ln == rl && px == 12) begin
               chk("rst_pre_lock", int'(locked), 1);
               reset_n = 1'b0;
               #1;
               chk("rst_flags", int'({pix_valid, sof, locked, err}), 0);
               chk("rst_xy", int'({pix_x, pix_y}), 0);
               chk("rst_rgb", int'({pix_r, pix_g, pix_b}), 0);
               chk("rst_tot", int'({h_total, v_total}), 0);
            end
            if (ln == rl && px == 13)
               reset_n = 1'b1;
         end
      end
   endtask

   task automatic hold_idle(input int n);
      repeat (n) begin
         @(negedge clk);
         hs = 1'b0;
         vs = 1'b0;
      end
   endtask

   task automatic monitor();
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (frame_id != seen_id) begin
            seen_id = frame_id;
            exp_x = 0;
            exp_y = 0;
         end
         if (err) begin
            err_tot++;
            chk("err_locked", int'(locked), 0);
            chk("err_valid", int'(pix_valid), 0);
         end
         if (pix_valid || sof) begin
            chk("sof_flag", int'(sof),
                int'(pix_valid && exp_x == 0 && exp_y == 0));
         end
         if (sof) begin
            sof_tot++;
            chk("sof_latency", cyc - a_cyc, 4);
            chk("sof_r", int'(pix_r), 8'hA5);
         end
         if (pix_valid) begin
            pix_tot++;
            chk("pix_x", int'(pix_x), exp_x);
            chk("pix_y", int'(pix_y), exp_y);
            chk("pix_rgb", int'({pix_r, pix_g, pix_b}),
                int'(col(exp_x + HST, exp_y + VST)));
            exp_x++;
            if (exp_x == HA) begin
               exp_x = 0;
               exp_y++;
            end
         end
      end
   endtask

   initial begin
      int p0, s0, e0;
      //          act sl  vse rl  lock pix sof err tot
      tbl[0]  = '{0, -1, 0, -1, 0,  0,  0, 0, 0};
      tbl[1]  = '{0, -1, 0, -1, 0,  0,  0, 0, 1};
      tbl[2]  = '{0, -1, 0, -1, 1, 96,  1, 0, 1};
      tbl[3]  = '{0, -1, 0, -1, 1, 96,  1, 0, 1};
      tbl[4]  = '{0,  5, 0, -1, 0, 48,  1, 1, 1};
      tbl[5]  = '{0, -1, 0, -1, 0,  0,  0, 0, 1};
      tbl[6]  = '{0, -1, 1, -1, 1, 96,  1, 0, 1};
      tbl[7]  = '{0, -1, 0, -1, 1, 96,  1, 0, 1};
      tbl[8]  = '{1, -1, 0, -1, 0,  0,  0, 1, 1};
      tbl[9]  = '{0, -1, 0, -1, 0,  0,  0, 0, 1};
      tbl[10] = '{0, -1, 0, -1, 0,  0,  0, 0, 1};
      tbl[11] = '{0, -1, 0, -1, 1, 96,  1, 0, 1};
      tbl[12] = '{0, -1, 0,  4, 0, -1,  1, 0, 0};
      tbl[13] = '{0, -1, 0, -1, 0,  0,  0, 0, 0};
      tbl[14] = '{0, -1, 0, -1, 0,  0,  0, 0, 1};
      tbl[15] = '{0, -1, 0, -1, 1, 96,  1, 0, 1};

      fork
         monitor();
      join_none

      #1;
      chk("reset_flags", int'({pix_valid, sof, locked, err}), 0);
      chk("reset_tot", int'({h_total, v_total}), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         p0 = pix_tot;
         s0 = sof_tot;
         e0 = err_tot;
         if (tbl[i].act == 1)
            hold_idle(4100);
         else
            drive_frame(tbl[i].sl, tbl[i].vse, tbl[i].rl);
         chk($sformatf("v%0d_locked", i), int'(locked), tbl[i].e_lock);
         if (tbl[i].e_pix >= 0)
            chk($sformatf("v%0d_pix", i), pix_tot - p0, tbl[i].e_pix);
         chk($sformatf("v%0d_sof", i), sof_tot - s0, tbl[i].e_sof);
         chk($sformatf("v%0d_err", i), err_tot - e0, tbl[i].e_err);
         if (tbl[i].ctot) begin
            chk($sformatf("v%0d_htot", i), int'(h_total), HT);
            chk($sformatf("v%0d_vtot", i), int'(v_total), VT);
         end
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
